// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch run/lap controller: channel state
// encodings and the default lap-counter width.
package stopwatch_pkg;

  // Channel run state; 2'b11 is unused and is recovered to ST_STOPPED.
  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_LAP     = 2'b10
  } swState_e;

  localparam int LAP_W_DEFAULT = 4;

endpackage

// File: rtl/stopwatch_ch_fsm.sv
// stopwatch_ch_fsm
// One stopwatch channel: button edge detection, STOPPED/RUNNING/LAP state
// machine and a saturating lap counter. All outputs come straight from flops.
// Ports:
//   clk5      system clock
//   reset     synchronous active-high reset
//   startPB   debounced start button
//   stopPB    debounced stop button
//   lapPB     debounced lap button (always edge-detected)
//   clearPB   debounced clear button (always edge-detected)
//   run       timebase enable (state != STOPPED)
//   hold      display freeze (state == LAP)
//   clear     one-cycle pulse to zero the time counter
//   lapCount  saturating lap-entry count
module stopwatch_ch_fsm
  import stopwatch_pkg::*;
#(
  parameter int LAP_W           = LAP_W_DEFAULT,
  parameter bit EDGE_START_STOP = 1'b1
) (
  input  logic             clk5,
  input  logic             reset,
  input  logic             startPB,
  input  logic             stopPB,
  input  logic             lapPB,
  input  logic             clearPB,
  output logic             run,
  output logic             hold,
  output logic             clear,
  output logic [LAP_W-1:0] lapCount
);

  swState_e         state_r, nextState_s;
  logic [LAP_W-1:0] lapCount_r, nextLapCount_s;
  logic             run_r, hold_r, clear_r;
  logic             nextRun_s, nextHold_s, nextClear_s;
  logic             startPrev_r, stopPrev_r, lapPrev_r, clearPrev_r;
  logic             evtStart_s, evtStop_s, evtLap_s, evtClear_s;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LAP_W-1:0] satInc(input logic [LAP_W-1:0] v);
    logic [LAP_W-1:0] res;
    if (v == {LAP_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + LAP_W'(1'b1);
    end
    return res;
  endfunction

  // Button events; start/stop may be level-sensitive for legacy behaviour.
  always_comb begin
    evtLap_s   = lapPB & ~lapPrev_r;
    evtClear_s = clearPB & ~clearPrev_r;
    if (EDGE_START_STOP) begin
      evtStart_s = startPB & ~startPrev_r;
      evtStop_s  = stopPB & ~stopPrev_r;
    end else begin
      evtStart_s = startPB;
      evtStop_s  = stopPB;
    end
  end

  // Next-state, lap count and clear pulse; stop beats lap, clear beats start.
  always_comb begin
    nextState_s    = state_r;
    nextLapCount_s = lapCount_r;
    nextClear_s    = 1'b0;
    case (state_r)
      ST_STOPPED: begin
        if (evtClear_s) begin
          nextClear_s    = 1'b1;
          nextLapCount_s = {LAP_W{1'b0}};
        end else if (evtStart_s) begin
          nextState_s = ST_RUNNING;
        end else begin
          nextState_s = ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        if (evtStop_s) begin
          nextState_s = ST_STOPPED;
        end else if (evtLap_s) begin
          nextState_s    = ST_LAP;
          nextLapCount_s = satInc(lapCount_r);
        end else begin
          nextState_s = ST_RUNNING;
        end
      end
      ST_LAP: begin
        if (evtStop_s) begin
          nextState_s = ST_STOPPED;
        end else if (evtLap_s) begin
          nextState_s = ST_RUNNING;
        end else begin
          nextState_s = ST_LAP;
        end
      end
      default: begin
        nextState_s = ST_STOPPED;
      end
    endcase
  end

  // Output decode of the next state so run/hold are flopped alongside state.
  always_comb begin
    case (nextState_s)
      ST_RUNNING: begin
        nextRun_s  = 1'b1;
        nextHold_s = 1'b0;
      end
      ST_LAP: begin
        nextRun_s  = 1'b1;
        nextHold_s = 1'b1;
      end
      default: begin
        nextRun_s  = 1'b0;
        nextHold_s = 1'b0;
      end
    endcase
  end

  // State, outputs and button history; history resets high so a button held
  // through reset does not fire on release.
  always_ff @(posedge clk5) begin
    if (reset) begin
      state_r     <= ST_STOPPED;
      lapCount_r  <= {LAP_W{1'b0}};
      run_r       <= 1'b0;
      hold_r      <= 1'b0;
      clear_r     <= 1'b0;
      startPrev_r <= 1'b1;
      stopPrev_r  <= 1'b1;
      lapPrev_r   <= 1'b1;
      clearPrev_r <= 1'b1;
    end else begin
      state_r     <= nextState_s;
      lapCount_r  <= nextLapCount_s;
      run_r       <= nextRun_s;
      hold_r      <= nextHold_s;
      clear_r     <= nextClear_s;
      startPrev_r <= startPB;
      stopPrev_r  <= stopPB;
      lapPrev_r   <= lapPB;
      clearPrev_r <= clearPB;
    end
  end

  assign run      = run_r;
  assign hold     = hold_r;
  assign clear    = clear_r;
  assign lapCount = lapCount_r;

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// stopwatch_run_ctrl
// Run/lap controller for NUM_CH independent stopwatch channels.
// Ports (all per-channel vectors, bit i = channel i):
//   clk5, reset                       clock and synchronous active-high reset
//   startPB, stopPB, lapPB, clearPB   debounced buttons
//   run, hold, clear                  timebase enable, display hold, clear pulse
//   lapCount                          channel i at [i*LAP_W +: LAP_W]
module stopwatch_run_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int LAP_W           = LAP_W_DEFAULT,
  parameter bit EDGE_START_STOP = 1'b1
) (
  input  logic                    clk5,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       startPB,
  input  logic [NUM_CH-1:0]       stopPB,
  input  logic [NUM_CH-1:0]       lapPB,
  input  logic [NUM_CH-1:0]       clearPB,
  output logic [NUM_CH-1:0]       run,
  output logic [NUM_CH-1:0]       hold,
  output logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH*LAP_W-1:0] lapCount
);

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    stopwatch_ch_fsm #(
      .LAP_W           (LAP_W),
      .EDGE_START_STOP (EDGE_START_STOP)
    ) uCh (
      .clk5     (clk5),
      .reset    (reset),
      .startPB  (startPB[i]),
      .stopPB   (stopPB[i]),
      .lapPB    (lapPB[i]),
      .clearPB  (clearPB[i]),
      .run      (run[i]),
      .hold     (hold[i]),
      .clear    (clear[i]),
      .lapCount (lapCount[i*LAP_W +: LAP_W])
    );
  end

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// tb_stopwatch_run_ctrl
// Directed bench: dutA (2 ch, LAP_W=4, edge mode), dutB (1 ch, LAP_W=2),
// dutC (1 ch, level-sensitive start/stop). Inputs change and outputs are
// sampled on the falling edge.
module tb_stopwatch_run_ctrl;

  logic clk5 = 1'b0;
  logic reset;
  int   errCnt = 0;
  int   chkCnt = 0;

  always #5 clk5 = ~clk5;

  logic [1:0] aStart, aStop, aLap, aClear, aRun, aHold, aClr;
  logic [7:0] aLapCnt;
  logic       bStart, bStop, bLap, bClear, bRun, bHold, bClr;
  logic [1:0] bLapCnt;
  logic       cStart, cStop, cLap, cClear, cRun, cHold, cClr;
  logic [3:0] cLapCnt;

  stopwatch_run_ctrl #(.NUM_CH(2), .LAP_W(4), .EDGE_START_STOP(1'b1)) dutA (
    .clk5(clk5), .reset(reset), .startPB(aStart), .stopPB(aStop),
    .lapPB(aLap), .clearPB(aClear), .run(aRun), .hold(aHold),
    .clear(aClr), .lapCount(aLapCnt));

  stopwatch_run_ctrl #(.NUM_CH(1), .LAP_W(2), .EDGE_START_STOP(1'b1)) dutB (
    .clk5(clk5), .reset(reset), .startPB(bStart), .stopPB(bStop),
    .lapPB(bLap), .clearPB(bClear), .run(bRun), .hold(bHold),
    .clear(bClr), .lapCount(bLapCnt));

  stopwatch_run_ctrl #(.NUM_CH(1), .LAP_W(4), .EDGE_START_STOP(1'b0)) dutC (
    .clk5(clk5), .reset(reset), .startPB(cStart), .stopPB(cStop),
    .lapPB(cLap), .clearPB(cClear), .run(cRun), .hold(cHold),
    .clear(cClr), .lapCount(cLapCnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk5);
      @(negedge clk5);
    end
  endtask

  initial begin
    reset  = 1'b1;
    aStart = 2'b01; aStop = 2'b00; aLap = 2'b00; aClear = 2'b00;
    bStart = 1'b0;  bStop = 1'b0;  bLap = 1'b0;  bClear = 1'b0;
    cStart = 1'b0;  cStop = 1'b0;  cLap = 1'b0;  cClear = 1'b0;
    @(negedge clk5);
    step(2);
    chk("rst aRun", aRun, 2'b00);
    chk("rst aHold", aHold, 2'b00);
    chk("rst aClr", aClr, 2'b00);
    chk("rst aLapCnt", aLapCnt, 8'h00);
    chk("rst bLapCnt", bLapCnt, 2'd0);
    chk("rst cRun", cRun, 1'b0);

    // startPB[0] held through reset must not start the channel.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held start", aRun[0], 1'b0);
    end
    aStart = 2'b00; step();
    chk("start low", aRun[0], 1'b0);
    aStart = 2'b01; step();
    chk("start edge", aRun[0], 1'b1);
    aStart = 2'b00; step();

    // lap, lap, lap: enter (1), exit, enter (2).
    aLap = 2'b01; step(); aLap = 2'b00;
    chk("lap1 hold", aHold[0], 1'b1);
    chk("lap1 cnt", aLapCnt[3:0], 4'd1);
    step(3);
    aLap = 2'b01; step(); aLap = 2'b00;
    chk("lap2 hold", aHold[0], 1'b0);
    chk("lap2 run", aRun[0], 1'b1);
    chk("lap2 cnt", aLapCnt[3:0], 4'd1);
    step(3);
    aLap = 2'b01; step(); aLap = 2'b00;
    chk("lap3 hold", aHold[0], 1'b1);
    chk("lap3 cnt", aLapCnt[3:0], 4'd2);
    step(3);
    aStop = 2'b01; step(); aStop = 2'b00;
    chk("stop run", aRun[0], 1'b0);
    chk("stop hold", aHold[0], 1'b0);
    chk("stop cnt", aLapCnt[3:0], 4'd2);
    step();

    // Both channels start together, stop ch1 only, ignored clear on ch0.
    aStart = 2'b11; step(); aStart = 2'b00;
    chk("dual start", aRun, 2'b11);
    step();
    aStop = 2'b10; step(); aStop = 2'b00;
    chk("stop ch1", aRun, 2'b01);
    aClear = 2'b01; step(); aClear = 2'b00;
    chk("clr ignored", aClr, 2'b00);
    chk("clr ign run", aRun, 2'b01);
    chk("clr ign cnt", aLapCnt[3:0], 4'd2);
    step();

    // stop and lap together: stop wins, no increment.
    aStop = 2'b01; aLap = 2'b01; step(); aStop = 2'b00; aLap = 2'b00;
    chk("stop+lap run", aRun[0], 1'b0);
    chk("stop+lap hold", aHold[0], 1'b0);
    chk("stop+lap cnt", aLapCnt[3:0], 4'd2);
    step();

    // start and clear together in STOPPED: clear wins.
    aStart = 2'b01; aClear = 2'b01; step(); aStart = 2'b00; aClear = 2'b00;
    chk("st+clr clr", aClr[0], 1'b1);
    chk("st+clr run", aRun[0], 1'b0);
    chk("st+clr cnt", aLapCnt[3:0], 4'd0);
    step();
    chk("clr 1cyc", aClr[0], 1'b0);

    // Build lapCount=5 in LAP state, then reset overrides a lap event.
    aStart = 2'b01; step(); aStart = 2'b00; step();
    for (int i = 0; i < 9; i++) begin
      aLap = 2'b01; step(); aLap = 2'b00; step();
    end
    chk("lap5 hold", aHold[0], 1'b1);
    chk("lap5 cnt", aLapCnt[3:0], 4'd5);
    reset = 1'b1; aLap = 2'b01; step(); aLap = 2'b00;
    chk("midrst run", aRun[0], 1'b0);
    chk("midrst hold", aHold[0], 1'b0);
    chk("midrst cnt", aLapCnt[3:0], 4'd0);
    reset = 1'b0; step();

    // LAP_W=2: five lap entries saturate at 3.
    bStart = 1'b1; step(); bStart = 1'b0;
    chk("b start", bRun, 1'b1);
    for (int i = 0; i < 9; i++) begin
      bLap = 1'b1; step(); bLap = 1'b0; step();
      if (i == 4) chk("b cnt3", bLapCnt, 2'd3);
    end
    chk("b sat", bLapCnt, 2'd3);
    chk("b sat hold", bHold, 1'b1);
    bStop = 1'b1; step(); bStop = 1'b0;
    chk("b stop run", bRun, 1'b0);
    chk("b stop cnt", bLapCnt, 2'd3);
    bClear = 1'b1; step();
    chk("b clr pulse", bClr, 1'b1);
    chk("b clr cnt", bLapCnt, 2'd0);
    step(); bClear = 1'b0;
    chk("b clr end", bClr, 1'b0);

    // Level mode: held start keeps running, stop level stops.
    cStart = 1'b1; step();
    chk("c start", cRun, 1'b1);
    step(3);
    chk("c held", cRun, 1'b1);
    cLap = 1'b1; step();
    chk("c lap edge", cHold, 1'b1);
    step();
    chk("c lap held", cHold, 1'b1);
    cLap = 1'b0; cStart = 1'b0; cStop = 1'b1; step();
    chk("c stop", cRun, 1'b0);
    chk("c stop hold", cHold, 1'b0);
    step();
    chk("c stop held", cRun, 1'b0);
    cStop = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_run_ctrl.md
Name: stopwatch_run_ctrl

Overview:
Parametrised run/lap controller for NUM_CH independent stopwatch channels. It replaces the single-channel start/stop run FSM. Each channel has internal rising-edge detection on four button inputs and a three-state FSM (STOPPED/RUNNING/LAP), and produces a run enable, a display-hold flag, a one-cycle clear pulse and a saturating lap counter. It sits between the debounced push-button inputs and the per-channel timebase counters and display mux, all on the clk5 domain.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
LAP_W, 4, width of each channel's lap counter
EDGE_START_STOP, 1, 1 = startPB/stopPB act on rising edge only; 0 = level-sensitive (legacy behaviour); lapPB/clearPB are always edge-detected

Ports:
clk5  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
startPB  input  NUM_CH  debounced start button per channel
stopPB  input  NUM_CH  debounced stop button per channel
lapPB  input  NUM_CH  debounced lap button per channel
clearPB  input  NUM_CH  debounced clear button per channel
run  output  NUM_CH  channel timebase enable
hold  output  NUM_CH  freeze display of channel (lap view)
clear  output  NUM_CH  one-cycle pulse: zero the channel's time counter
lapCount  output  NUM_CH*LAP_W  lap count; channel i occupies bits [i*LAP_W +: LAP_W]

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset: state=STOPPED, run=0, hold=0, clear=0, lapCount=0. Button-history registers reset to all ones, so a button held through reset does not fire on reset release.
- Edge: evt = PB & ~PB_prev, where PB_prev is the registered previous sample. An event is acted on at the same clk5 edge that updates PB_prev. run/hold/clear/lapCount change at the first edge that samples the button high after a low sample. There is no further latency.
- In level mode (EDGE_START_STOP=0), evt_start=startPB and evt_stop=stopPB.
- All outputs are registered (run = state!=STOPPED, hold = state==LAP, decoded from the state register).
- STOPPED:
  - clear evt -> stay STOPPED, clear pulses 1 cycle, lapCount<=0.
  - Otherwise start evt -> RUNNING.
  - clear and start in the same cycle: clear wins, start is dropped.
- RUNNING:
  - stop evt -> STOPPED.
  - Otherwise lap evt -> LAP, lapCount<=lapCount+1, saturating at 2^LAP_W-1.
  - stop and lap in the same cycle: stop wins, no increment.
  - start and clear are ignored.
- LAP (run=1, hold=1):
  - stop evt -> STOPPED, hold drops.
  - Otherwise lap evt -> RUNNING, hold drops, no increment.
  - start and clear are ignored.
- An illegal state encoding returns to STOPPED on the next edge.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.
- Reset asserted mid-operation overrides every event in that cycle. Outputs equal their reset values after that edge.

Decomposition:
- Package stopwatch_pkg:
  - 2-bit state encodings ST_STOPPED=2'b00, ST_RUNNING=2'b01, ST_LAP=2'b10.
  - Default LAP_W.
- Sub-module stopwatch_ch_fsm: one channel (edge detect, FSM, lap counter), parameters LAP_W and EDGE_START_STOP.
- Top instantiates NUM_CH copies in a generate loop and packs lapCount.

Test Plan:
- Reset with startPB[0] held high, release reset, keep it high 10 cycles -> run[0]=0 throughout. Drop startPB[0], raise it again -> run[0]=1 after that edge.
- Ch0: start, lap, lap, lap (each a 1-cycle pulse, gaps of 3 cycles) -> hold toggles 1/0/1, lapCount[3:0]=2. Then stop -> run=0, hold=0, lapCount=2.
- LAP_W=2: 5 lap entries on ch0 -> lapCount saturates at 3. Stop, then clear -> clear=1 for exactly 1 cycle, lapCount=0.
- RUNNING ch0, assert stopPB and lapPB in the same cycle -> run=0, hold=0, lapCount unchanged. STOPPED, start+clear together -> clear pulse, run stays 0.
- NUM_CH=2: start ch0 and ch1 in the same cycle, stop ch1 only -> run=2'b01. clearPB[0] while ch0 is running -> no clear pulse.
- Assert reset while ch0 is in LAP with lapCount=5 -> next edge: run=0, hold=0, lapCount=0. EDGE_START_STOP=0 with startPB held -> run stays 1 and stop level returns it to STOPPED.
